// File: rtl/idma_desc64_pkg.sv
// Shared types for the desc64 frontend: assembled descriptor layout and beat order.
package idma_desc64_pkg;

  localparam int unsigned BeatsPerDesc = 4;
  localparam logic [63:0] EndOfChain   = '1;

  typedef struct packed {
    logic [31:0] flags;
    logic [31:0] length;
    logic [63:0] next;
    logic [63:0] src;
    logic [63:0] dst;
    logic        err;
  } descriptor_t;

  typedef enum logic [$clog2(BeatsPerDesc)-1:0] {
    BeatLen  = 2'd0,
    BeatNext = 2'd1,
    BeatSrc  = 2'd2,
    BeatDst  = 2'd3
  } beat_e;

endpackage

// File: rtl/idma_desc64_reader_assembler.sv
// Collects four 64-bit R beats into one descriptor and presents it on a valid/ready output.
// Optional IDMA_DESC64_READER_ERR_EN: sticky capture of SLVERR/DECERR into desc_o.err.
module idma_desc64_reader_assembler
  import idma_desc64_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] r_data_i,
  input  logic [1:0]  r_resp_i,
  input  logic        r_last_i,
  input  logic        r_valid_i,
  output logic        r_ready_o,
  output descriptor_t desc_o,
  output logic        desc_valid_o,
  input  logic        desc_ready_i,
  output logic        complete_o,
  output logic [63:0] next_o
);

  beat_e       beat_cnt_q, beat_cnt_d;
  descriptor_t desc_q, desc_d;
  logic        desc_valid_q, desc_valid_d;
  logic        accept;
  logic        unused_resp;

  // The output slot frees up in the same cycle it is consumed, so beat 0 of the
  // next descriptor can land while the previous one is being taken.
  assign r_ready_o    = !desc_valid_q || desc_ready_i;
  assign accept       = r_valid_i && r_ready_o;
  assign complete_o   = accept && (beat_cnt_q == BeatDst);
  assign next_o       = desc_q.next;
  assign desc_o       = desc_q;
  assign desc_valid_o = desc_valid_q;
  assign unused_resp  = ^r_resp_i;

`ifdef IDMA_DESC64_READER_ERR_EN
  logic err_q, err_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`endif

  always_comb begin
    beat_cnt_d   = beat_cnt_q;
    desc_d       = desc_q;
    desc_valid_d = desc_valid_q && !desc_ready_i;
    if (accept) begin
      unique case (beat_cnt_q)
        BeatLen: begin
          desc_d.length = r_data_i[31:0];
          desc_d.flags  = r_data_i[63:32];
          beat_cnt_d    = BeatNext;
        end
        BeatNext: begin
          desc_d.next = r_data_i;
          beat_cnt_d  = BeatSrc;
        end
        BeatSrc: begin
          desc_d.src = r_data_i;
          beat_cnt_d = BeatDst;
        end
        BeatDst: begin
          desc_d.dst   = r_data_i;
          beat_cnt_d   = BeatLen;
          desc_valid_d = 1'b1;
        end
      endcase
    end
`ifdef IDMA_DESC64_READER_ERR_EN
    err_d = err_q | (accept & r_resp_i[1]);
    if (complete_o) begin
      desc_d.err = err_d;
      err_d      = 1'b0;
    end
`else
    desc_d.err = 1'b0;
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beat_cnt_q   <= BeatLen;
      desc_q       <= '0;
      desc_valid_q <= 1'b0;
    end else begin
      beat_cnt_q   <= beat_cnt_d;
      desc_q       <= desc_d;
      desc_valid_q <= desc_valid_d;
    end
  end

  a_last_on_final_beat: assert property (
    @(posedge clk_i) disable iff (rst_i)
    accept |-> (r_last_i == (beat_cnt_q == BeatDst))
  );

endmodule

// File: rtl/idma_desc64_reader.sv
// Desc64 R-channel reader: assembles descriptors and tells the gater how many
// speculative fetches to drop at end of chain. Optional IDMA_DESC64_READER_ERR_EN.
module idma_desc64_reader
  import idma_desc64_pkg::*;
#(
  parameter int unsigned DataWidth    = 64,
  parameter int unsigned MaxSpec      = 4,
  parameter type         flush_t      = logic [$clog2(MaxSpec+1)-1:0],
  parameter type         descriptor_t = idma_desc64_pkg::descriptor_t
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 fetch_issued_i,
  input  logic [DataWidth-1:0] r_data_i,
  input  logic [1:0]           r_resp_i,
  input  logic                 r_last_i,
  input  logic                 r_valid_i,
  output logic                 r_ready_o,
  output descriptor_t          desc_o,
  output logic                 desc_valid_o,
  input  logic                 desc_ready_i,
  output flush_t               n_to_flush_o,
  output logic                 n_to_flush_valid_o
);

  flush_t      pending_q, pending_d, pending_sum;
  flush_t      n_to_flush_q, n_to_flush_d;
  logic        n_to_flush_valid_q, n_to_flush_valid_d;
  logic        complete;
  logic [63:0] next_ptr;

  idma_desc64_reader_assembler u_asm (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .r_data_i     (r_data_i),
    .r_resp_i     (r_resp_i),
    .r_last_i     (r_last_i),
    .r_valid_i    (r_valid_i),
    .r_ready_o    (r_ready_o),
    .desc_o       (desc_o),
    .desc_valid_o (desc_valid_o),
    .desc_ready_i (desc_ready_i),
    .complete_o   (complete),
    .next_o       (next_ptr)
  );

  // At end of chain every fetch still in flight (including one issued this
  // cycle) is reported for flushing; only this cycle's issue stays pending.
  always_comb begin
    pending_sum        = pending_q + flush_t'(fetch_issued_i) - flush_t'(complete);
    pending_d          = pending_sum;
    n_to_flush_d       = n_to_flush_q;
    n_to_flush_valid_d = 1'b0;
    if (complete && (next_ptr == EndOfChain)) begin
      n_to_flush_d       = pending_sum;
      n_to_flush_valid_d = 1'b1;
      pending_d          = flush_t'(fetch_issued_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q          <= '0;
      n_to_flush_q       <= '0;
      n_to_flush_valid_q <= 1'b0;
    end else begin
      pending_q          <= pending_d;
      n_to_flush_q       <= n_to_flush_d;
      n_to_flush_valid_q <= n_to_flush_valid_d;
    end
  end

  assign n_to_flush_o       = n_to_flush_q;
  assign n_to_flush_valid_o = n_to_flush_valid_q;

endmodule

// File: tb/tb_idma_desc64_reader.sv
// Directed self-checking bench for idma_desc64_reader (covers IDMA_DESC64_READER_ERR_EN builds too).
module tb_idma_desc64_reader;
  import idma_desc64_pkg::*;

`ifdef IDMA_DESC64_READER_ERR_EN
  localparam logic ErrExp = 1'b1;
`else
  localparam logic ErrExp = 1'b0;
`endif

  logic        clk_i          = 1'b0;
  logic        rst_i          = 1'b1;
  logic        fetch_issued_i = 1'b0;
  logic [63:0] r_data_i       = '0;
  logic [1:0]  r_resp_i       = '0;
  logic        r_last_i       = 1'b0;
  logic        r_valid_i      = 1'b0;
  logic        r_ready_o;
  descriptor_t desc_o;
  logic        desc_valid_o;
  logic        desc_ready_i   = 1'b1;
  logic [2:0]  n_to_flush_o;
  logic        n_to_flush_valid_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  idma_desc64_reader #(
    .DataWidth (64),
    .MaxSpec   (4)
  ) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .fetch_issued_i     (fetch_issued_i),
    .r_data_i           (r_data_i),
    .r_resp_i           (r_resp_i),
    .r_last_i           (r_last_i),
    .r_valid_i          (r_valid_i),
    .r_ready_o          (r_ready_o),
    .desc_o             (desc_o),
    .desc_valid_o       (desc_valid_o),
    .desc_ready_i       (desc_ready_i),
    .n_to_flush_o       (n_to_flush_o),
    .n_to_flush_valid_o (n_to_flush_valid_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input int n);
    for (int i = 0; i < n; i++) begin
      fetch_issued_i = 1'b1;
      tick();
    end
    fetch_issued_i = 1'b0;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_beat(input logic [63:0] d, input logic last, input logic [1:0] resp);
    int n;
    n = 0;
    r_data_i  = d;
    r_last_i  = last;
    r_resp_i  = resp;
    r_valid_i = 1'b1;
    #3;
    while (r_ready_o !== 1'b1 && n < 20) begin
      @(posedge clk_i);
      #3;
      n++;
    end
    chk("beat_ready", r_ready_o, 1'b1);
    @(posedge clk_i);
    #1;
    r_valid_i = 1'b0;
    r_last_i  = 1'b0;
    r_resp_i  = '0;
  endtask

  task automatic send_desc(input logic [63:0] b0, input logic [63:0] b1,
                           input logic [63:0] b2, input logic [63:0] b3,
                           input logic [1:0] resp2);
    send_beat(b0, 1'b0, 2'b00);
    send_beat(b1, 1'b0, 2'b00);
    send_beat(b2, 1'b0, resp2);
    send_beat(b3, 1'b1, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_r_ready", r_ready_o, 1'b1);
    chk("rst_desc_valid", desc_valid_o, 1'b0);
    chk("rst_flush_valid", n_to_flush_valid_o, 1'b0);
    chk("rst_n_to_flush", n_to_flush_o, 3'd0);
    chk("rst_desc_dst", desc_o.dst, 64'h0);
    rst_i = 1'b0;
    tick();

    // Single descriptor, one-cycle latency from last beat
    fetch(1);
    send_beat(64'h0000_0003_0000_0100, 1'b0, 2'b00);
    send_beat(64'h1000, 1'b0, 2'b00);
    send_beat(64'h2000, 1'b0, 2'b00);
    chk("t1_valid_before_last", desc_valid_o, 1'b0);
    send_beat(64'h3000, 1'b1, 2'b00);
    chk("t1_valid", desc_valid_o, 1'b1);
    chk("t1_length", desc_o.length, 32'h100);
    chk("t1_flags", desc_o.flags, 32'h3);
    chk("t1_next", desc_o.next, 64'h1000);
    chk("t1_src", desc_o.src, 64'h2000);
    chk("t1_dst", desc_o.dst, 64'h3000);
    chk("t1_no_flush", n_to_flush_valid_o, 1'b0);
    chk("t1_pending", dut.pending_q, 3'd0);
    tick();
    chk("t1_valid_consumed", desc_valid_o, 1'b0);
    chk("t1_no_flush_later", n_to_flush_valid_o, 1'b0);

    // Backpressure with beat 0 of the next descriptor waiting
    desc_ready_i = 1'b0;
    fetch(2);
    send_desc(64'h0000_0001_0000_0040, 64'h1100, 64'h2100, 64'h3100, 2'b00);
    r_data_i  = 64'h0000_0005_0000_0200;
    r_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #3;
      chk("t2_stall_r_ready", r_ready_o, 1'b0);
      chk("t2_stall_valid", desc_valid_o, 1'b1);
      chk("t2_stall_length", desc_o.length, 32'h40);
      chk("t2_stall_dst", desc_o.dst, 64'h3100);
      @(posedge clk_i);
      #1;
    end
    desc_ready_i = 1'b1;
    #3;
    chk("t2_release_r_ready", r_ready_o, 1'b1);
    @(posedge clk_i);
    #1;
    r_valid_i = 1'b0;
    chk("t2_consumed", desc_valid_o, 1'b0);
    send_beat(64'h1200, 1'b0, 2'b00);
    send_beat(64'h2200, 1'b0, 2'b00);
    send_beat(64'h3200, 1'b1, 2'b00);
    chk("t2_b_valid", desc_valid_o, 1'b1);
    chk("t2_b_length", desc_o.length, 32'h200);
    chk("t2_b_flags", desc_o.flags, 32'h5);
    chk("t2_b_next", desc_o.next, 64'h1200);
    chk("t2_b_dst", desc_o.dst, 64'h3200);
    chk("t2_pending", dut.pending_q, 3'd0);
    tick();

    // End of chain with two speculative fetches behind it
    fetch(3);
    chk("t3_pending_before", dut.pending_q, 3'd3);
    send_desc(64'h0000_0000_0000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'h4000, 64'h5000, 2'b00);
    chk("t3_flush_valid", n_to_flush_valid_o, 1'b1);
    chk("t3_n_to_flush", n_to_flush_o, 3'd2);
    chk("t3_pending_after", dut.pending_q, 3'd0);
    chk("t3_next_eoc", desc_o.next, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    chk("t3_flush_pulse_end", n_to_flush_valid_o, 1'b0);

    // Fetch issued in the same cycle as end-of-chain completion
    fetch(1);
    send_beat(64'h0000_0000_0000_0020, 1'b0, 2'b00);
    send_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2'b00);
    send_beat(64'h6000, 1'b0, 2'b00);
    fetch_issued_i = 1'b1;
    send_beat(64'h7000, 1'b1, 2'b00);
    fetch_issued_i = 1'b0;
    chk("t4_flush_valid", n_to_flush_valid_o, 1'b1);
    chk("t4_n_to_flush", n_to_flush_o, 3'd1);
    chk("t4_pending_after", dut.pending_q, 3'd1);
    tick();

    // Reset after beat 1 of a descriptor
    send_beat(64'h0000_0007_0000_0999, 1'b0, 2'b00);
    send_beat(64'hAAAA, 1'b0, 2'b00);
    rst_i = 1'b1;
    #2;
    chk("t5_rst_r_ready", r_ready_o, 1'b1);
    chk("t5_rst_desc_valid", desc_valid_o, 1'b0);
    chk("t5_rst_flush_valid", n_to_flush_valid_o, 1'b0);
    chk("t5_rst_n_to_flush", n_to_flush_o, 3'd0);
    chk("t5_rst_pending", dut.pending_q, 3'd0);
    chk("t5_rst_length", desc_o.length, 32'h0);
    chk("t5_rst_src", desc_o.src, 64'h0);
    tick();
    rst_i = 1'b0;
    tick();
    fetch(1);
    send_desc(64'h0000_0002_0000_0300, 64'h1300, 64'h2300, 64'h3300, 2'b00);
    chk("t5_valid", desc_valid_o, 1'b1);
    chk("t5_length", desc_o.length, 32'h300);
    chk("t5_flags", desc_o.flags, 32'h2);
    chk("t5_next", desc_o.next, 64'h1300);
    chk("t5_src", desc_o.src, 64'h2300);
    chk("t5_dst", desc_o.dst, 64'h3300);
    tick();

    // Error response on beat 2, followed by a clean descriptor
    fetch(2);
    send_desc(64'h0000_0000_0000_0400, 64'h1400, 64'h2400, 64'h3400, 2'b10);
    chk("t6_err_desc_valid", desc_valid_o, 1'b1);
    chk("t6_err_flag", desc_o.err, ErrExp);
    tick();
    send_desc(64'h0000_0000_0000_0500, 64'h1500, 64'h2500, 64'h3500, 2'b00);
    chk("t6_clean_length", desc_o.length, 32'h500);
    chk("t6_clean_err", desc_o.err, 1'b0);
    chk("t6_pending", dut.pending_q, 3'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/idma_desc64_reader.md
Name: idma_desc64_reader

Overview:
- Sits directly downstream of the R-channel gater in the desc64 frontend.
- Consumes the gated 64-bit AXI R beats of descriptor fetches and assembles each 4-beat chain descriptor into one descriptor word.
- Tracks speculative descriptor fetches in flight. When the end of the chain is seen, it tells the gater how many trailing fetches to discard (n_to_flush).

Parameters:
- DataWidth, 64, R data width; only 64 is supported.
- MaxSpec, 4, maximum speculative descriptor fetches outstanding.
- flush_t, logic [$clog2(MaxSpec+1)-1:0], flush count type; identical to the gater's flush_t.
- descriptor_t, idma_desc64_pkg::descriptor_t, assembled descriptor struct.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- fetch_issued_i  in  1  one descriptor AR handshake occurred this cycle.
- r_data_i  in  64  R data from the gater.
- r_resp_i  in  2  R response.
- r_last_i  in  1  R last.
- r_valid_i  in  1  R valid from the gater.
- r_ready_o  out  1  R ready to the gater.
- desc_o  out  descriptor_t  assembled descriptor.
- desc_valid_o  out  1  descriptor valid.
- desc_ready_i  in  1  descriptor ready from downstream.
- n_to_flush_o  out  flush_t  fetches to discard.
- n_to_flush_valid_o  out  1  one-cycle strobe for n_to_flush_o.

Behaviour:
- Reset values:
  - All outputs 0, except r_ready_o = 1.
  - beat_cnt_q = 0, pending_q = 0, desc_valid_q = 0.
- Beat mapping (beat_cnt_q, 2 bits):
  - Beat 0: [31:0] -> length, [63:32] -> flags.
  - Beat 1: next pointer.
  - Beat 2: src address.
  - Beat 3: dst address.
- Beat acceptance:
  - A beat is accepted when r_valid_i && r_ready_o.
  - r_ready_o = !desc_valid_q || desc_ready_i. A descriptor is accepted downstream in the same cycle that beat 0 of the next one arrives.
  - Beats 0-2 increment beat_cnt_q.
- Descriptor completion (beat 3 accepted):
  - beat_cnt_q wraps to 0.
  - desc_valid_q sets on the next cycle, so latency is 1 cycle from the last beat to desc_valid_o.
  - desc_o is held stable while desc_valid_o && !desc_ready_i.
- Pending counter:
  - pending_d = pending_q + fetch_issued_i − completion.
  - Simultaneous issue and completion leaves the count unchanged.
  - Upstream never exceeds MaxSpec.
- End of chain: a completed descriptor with next == 64'hFFFF_FFFF_FFFF_FFFF.
  - On the next cycle, n_to_flush_valid_o pulses for exactly 1 cycle with n_to_flush_o = pending_d at completion, i.e. fetches still in flight after this one.
  - pending_q is cleared to fetch_issued_i of that cycle.
  - Flushed fetches are invisible here because the gater swallows their beats.
- Non-end descriptors never pulse n_to_flush_valid_o.
- r_last_i:
  - Expected only on beat 3.
  - r_last_i on beats 0-2 or missing on beat 3 is a protocol violation: assertion fires, and beat_cnt_q still follows the beat count.
- Reset mid-descriptor discards the partial beats and the pending count.

Optional Feature:
- Macro: IDMA_DESC64_READER_ERR_EN.
- Defined:
  - A sticky err_q captures any r_resp_i[1] == 1 (SLVERR/DECERR) within a descriptor.
  - desc_o.err reports err_q; err_q clears at completion.
  - An errored end-of-chain descriptor still triggers the flush.
- Undefined: r_resp_i is ignored and desc_o.err is tied 0.

Decomposition:
- idma_desc64_pkg holds:
  - descriptor_t (flags, length, next, src, dst, err).
  - constant EndOfChain = '1.
  - constant BeatsPerDesc = 4.
- One sub-module: idma_desc64_reader_assembler. It holds the beat counter, field capture and output register with the valid/ready handshake.
- The top level keeps the pending counter and flush logic.

Test Plan:
- Single descriptor: fetch_issued_i pulse, beats {0x0000_0003_0000_0100, 0x1000, 0x2000, 0x3000} with last on beat 3.
  - Required: desc_valid_o 1 cycle later with length = 0x100, flags = 3, next = 0x1000, src = 0x2000, dst = 0x3000.
  - Required: no flush strobe.
- Backpressure: hold desc_ready_i = 0 for 5 cycles after completion, with beat 0 of the next descriptor waiting.
  - Required: r_ready_o = 0 and desc_o stable during the stall.
  - Required: in the cycle desc_ready_i rises, beat 0 is accepted.
- End of chain with speculation: 3 fetches issued, first descriptor next = all ones.
  - Required: n_to_flush_valid_o for 1 cycle with n_to_flush_o = 2; pending_q = 0 afterwards.
- Simultaneous events: fetch_issued_i in the same cycle as an end-of-chain completion with pending_q = 1.
  - Required: n_to_flush_o = 1; pending_q = 1 afterwards.
- Reset: assert rst_i after beat 1 of a descriptor.
  - Required: outputs return to reset values.
  - Required: the next 4 beats assemble cleanly starting at beat 0.
- ERR_EN: beat 2 with r_resp_i = 2'b10.
  - Required: desc_o.err = 1 on that descriptor and 0 on the following clean descriptor.
